// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: keeps a fetch PC, issues one-cycle-latency imem reads and
// queues {instr, pc+4} for decode. Define IF_STALL_CNT_EN to add the stall_cnt output.
module if_prefetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00400020
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   input  logic                  id_ready,
   output logic                  id_valid,
   output logic [DATA_WIDTH-1:0] id_instr,
`ifdef IF_STALL_CNT_EN
   output logic [DATA_WIDTH-1:0] id_pc_plus4,
   output logic [31:0]           stall_cnt
`else
   output logic [DATA_WIDTH-1:0] id_pc_plus4
`endif
);
   localparam int              AW   = $clog2(DEPTH);
   localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] fetch_pc, req_pc4;
   logic                  inflight;
   logic [AW-1:0]         wptr, rptr;
   logic [AW:0]           count, occupancy;
   logic                  push, pop;
   logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] pc4_mem   [DEPTH];

   // In-flight responses reserve a slot so the FIFO can never overflow.
   assign occupancy = count + {{AW{1'b0}}, inflight};
   assign imem_req  = rstb && !redirect && (occupancy < FULL);
   assign imem_addr = fetch_pc;
   assign push      = inflight && !redirect;
   assign pop       = id_valid && id_ready && !redirect;

   assign id_valid    = (count != '0);
   assign id_instr    = id_valid ? instr_mem[rptr] : '0;
   assign id_pc_plus4 = id_valid ? pc4_mem[rptr]   : '0;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         fetch_pc <= RESET_PC;
         req_pc4  <= '0;
         inflight <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            req_pc4  <= fetch_pc + DATA_WIDTH'(4);
         end
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wptr] <= imem_rdata;
         pc4_mem[wptr]   <= req_pc4;
      end
   end

`ifdef IF_STALL_CNT_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)
         stall_cnt <= '0;
      else if (!id_valid && (stall_cnt != 32'hFFFFFFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: doc/if_prefetch_unit.md
IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction and PC width.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 32'h00400020: fetch PC after reset.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rstb, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port redirect, input, 1: taken branch or jump; flush and refetch.
REQ-007 SHALL have port redirect_pc, input, DATA_WIDTH: redirect target.
REQ-008 SHALL have port imem_req, output, 1: instruction memory read strobe.
REQ-009 SHALL have port imem_addr, output, DATA_WIDTH: read address (current fetch PC).
REQ-010 SHALL have port imem_rdata, input, DATA_WIDTH: read data, valid exactly 1 cycle after imem_req.
REQ-011 SHALL have port id_ready, input, 1: decode accepts the head entry.
REQ-012 SHALL have port id_valid, output, 1: FIFO head valid.
REQ-013 SHALL have port id_instr, output, DATA_WIDTH: head instruction; 0 (NOP) when id_valid=0.
REQ-014 SHALL have port id_pc_plus4, output, DATA_WIDTH: head PC+4; 0 when id_valid=0.

Function
REQ-015 SHALL hold fetch_pc; imem_addr=fetch_pc combinationally.
REQ-016 SHALL assert imem_req=1 when (count + inflight) < DEPTH and redirect=0; fetch_pc then advances by 4 at the clock edge.
REQ-017 SHALL set inflight=1 the cycle after a request and push {imem_rdata, addr+4} into the FIFO at that edge, unless the response is squashed.
REQ-018 SHALL assert id_valid on the cycle after a push into an empty FIFO (2-cycle fetch-to-decode latency).
REQ-019 SHALL pop the head on id_valid && id_ready; with push and pop on the same edge, count SHALL stay unchanged.
REQ-020 SHALL issue no request when full (count + inflight = DEPTH); imem_req=0 and fetch_pc SHALL hold.
REQ-021 On redirect=1, at the next edge SHALL: set fetch_pc=redirect_pc, set count=0, drop any in-flight response, and not push.
REQ-022 A redirect SHALL take priority over a simultaneous pop and push; id_valid SHALL be 0 on the following cycle.
REQ-023 A redirect SHALL deassert imem_req in its own cycle; fetch from redirect_pc SHALL start on the next cycle.
REQ-024 PC arithmetic SHALL be modulo 2^DATA_WIDTH; 32'hFFFFFFFC+4 SHALL wrap to 0 without error.
REQ-025 FIFO read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap naturally; count SHALL be log2(DEPTH)+1 bits.
REQ-026 Back-to-back redirects SHALL each take effect; only the last target SHALL be fetched.

Reset
REQ-027 On rstb=0, asynchronously: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, id_valid=0, id_instr=0, id_pc_plus4=0.
REQ-028 imem_req SHALL be 0 while rstb=0 and SHALL assert in the first cycle after release.
REQ-029 Reset mid-operation SHALL discard all FIFO contents and in-flight data.

Configuration
REQ-030 With IF_STALL_CNT_EN defined, SHALL add output stall_cnt [31:0]: counts cycles with id_valid=0 and rstb=1, saturates at 32'hFFFFFFFF, and resets to 0.
REQ-031 Without IF_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset release, id_ready=1, memory returns addr as data -> imem_addr 0x00400020, 0x00400024, ...; first id_valid 2 cycles after release with id_instr=0x00400020, id_pc_plus4=0x00400024.
REQ-033 id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, imem_req=0 afterwards, fetch_pc=0x00400030 held; releasing id_ready drains entries in order.
REQ-034 redirect=1, redirect_pc=0x00400100 with FIFO holding 3 entries and one in flight -> next cycle id_valid=0, in-flight data not delivered, next imem_addr=0x00400100.
REQ-035 redirect on the same cycle as pop and push -> count=0 afterwards; first delivered id_pc_plus4=0x00400104 for target 0x00400100.
REQ-036 redirect_pc=32'hFFFFFFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; id_pc_plus4 for 0xFFFFFFFC is 0.
REQ-037 Assert rstb=0 mid-stream, with IF_STALL_CNT_EN defined -> outputs zero immediately, stall_cnt=0, fetch restarts at 0x00400020.
